// File: rtl/sram_pkg.sv
// Shared types and helpers for the 1RW+1R SRAM behavioural model.
package sram_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } sram_init_state_t;

  function automatic int unsigned sram_num_wmasks(input int unsigned data_width,
                                                  input int unsigned wmask_gran);
    return data_width / wmask_gran;
  endfunction

endpackage

// File: rtl/sram_1rw1r_model_if.sv
// Port bundle for the 1RW+1R SRAM model: port 0 read/write, port 1 read-only.
interface sram_1rw1r_model_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_WMASKS = 16
);
  import sram_pkg::*;

  // Access qualification: a port acts on an edge only when its csb is low and
  // ready is high; any access presented while ready is low is dropped.
  logic                  csb0;
  logic                  web0;
  logic [NUM_WMASKS-1:0] wmask0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] dout0;
  logic                  csb1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] dout1;
  logic                  ready;
  sram_init_state_t      dbg_state;

  modport master (
    output csb0, web0, wmask0, addr0, din0, csb1, addr1,
    input  dout0, dout1, ready, dbg_state
  );

  modport slave (
    input  csb0, web0, wmask0, addr0, din0, csb1, addr1,
    output dout0, dout1, ready, dbg_state
  );

endinterface

// File: rtl/sram_wmask_merge.sv
// Lane merge: replaces each WMASK_GRAN-bit lane of the old word with din where its mask bit is set.
module sram_wmask_merge #(
  parameter int DATA_WIDTH = 128,
  parameter int WMASK_GRAN = 8,
  parameter int NUM_WMASKS = DATA_WIDTH / WMASK_GRAN
) (
  input  logic [DATA_WIDTH-1:0] old_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic [NUM_WMASKS-1:0] wmask_i,
  output logic [DATA_WIDTH-1:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int i = 0; i < NUM_WMASKS; i++) begin
      if (wmask_i[i]) begin
        merged_o[i*WMASK_GRAN +: WMASK_GRAN] = din_i[i*WMASK_GRAN +: WMASK_GRAN];
      end
    end
  end

endmodule

// File: rtl/sram_1rw1r_model.sv
// 1RW+1R synchronous SRAM model with a post-reset clear walk and write-first port-1 bypass.
module sram_1rw1r_model
  import sram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 128,
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    WMASK_GRAN = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                clk0,
  input  logic                rst0_n,
  sram_1rw1r_model_if.slave   bus
);

  localparam int RAM_DEPTH  = 2 ** ADDR_WIDTH;
  localparam int NUM_WMASKS = int'(sram_num_wmasks(DATA_WIDTH, WMASK_GRAN));

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  if (DATA_WIDTH % WMASK_GRAN != 0) begin : g_bad_gran
    $error("sram_1rw1r_model: DATA_WIDTH must be a multiple of WMASK_GRAN");
  end

  logic [0:0]            state_q,   state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_WIDTH-1:0] dout0_q,   dout0_d;
  logic [DATA_WIDTH-1:0] dout1_q,   dout1_d;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  is_ready;
  logic                  p0_wr;
  logic                  p0_rd;
  logic                  p1_rd;
  logic                  p1_bypass;
  logic [DATA_WIDTH-1:0] wr_merged;

  assign is_ready  = (state_q == ST_READY);
  assign p0_wr     = is_ready && !bus.csb0 && !bus.web0;
  assign p0_rd     = is_ready && !bus.csb0 &&  bus.web0;
  assign p1_rd     = is_ready && !bus.csb1;
  assign p1_bypass = p0_wr && (bus.addr1 == bus.addr0);

  // One merge instance serves both the array write and the port-1 bypass,
  // because the bypass only applies when both ports address the same entry.
  sram_wmask_merge #(
    .DATA_WIDTH (DATA_WIDTH),
    .WMASK_GRAN (WMASK_GRAN),
    .NUM_WMASKS (NUM_WMASKS)
  ) u_merge (
    .old_i    (mem[bus.addr0]),
    .din_i    (bus.din0),
    .wmask_i  (bus.wmask0),
    .merged_o (wr_merged)
  );

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
        state_d = ST_READY;
      end else begin
        clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
      end
    end
  end

  always_comb begin
    dout0_d = dout0_q;
    dout1_d = dout1_q;
    if (p0_rd) begin
      dout0_d = mem[bus.addr0];
    end
    if (p1_rd) begin
      dout1_d = p1_bypass ? wr_merged : mem[bus.addr1];
    end
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      dout0_q   <= '0;
      dout1_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      dout0_q   <= dout0_d;
      dout1_q   <= dout1_d;
    end
  end

  // The array has no reset; contents are initialised only by the clear walk.
  always_ff @(posedge clk0) begin
    if (state_q == ST_CLEAR) begin
      mem[clr_cnt_q] <= INIT_VALUE;
    end else if (p0_wr) begin
      mem[bus.addr0] <= wr_merged;
    end
  end

  assign bus.dout0     = dout0_q;
  assign bus.dout1     = dout1_q;
  assign bus.ready     = is_ready;
  assign bus.dbg_state = sram_init_state_t'(state_q);

endmodule

// File: tb/tb_sram_1rw1r_model.sv
// Randomised bench for sram_1rw1r_model against an array-based reference model.
module tb_sram_1rw1r_model;
  import sram_pkg::*;

  localparam int DW    = 128;
  localparam int AW    = 6;
  localparam int NM    = 16;
  localparam int DEPTH = 64;

  // ---------------- clock / reset ----------------
  logic clk0 = 1'b0;
  logic rst0_n;
  always #5 clk0 = ~clk0;

  sram_1rw1r_model_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NM)) bus ();

  sram_1rw1r_model #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .WMASK_GRAN (8),
    .INIT_VALUE ({DW{1'b0}})
  ) dut (
    .clk0   (clk0),
    .rst0_n (rst0_n),
    .bus    (bus)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_dout0;
  logic [DW-1:0] exp_dout1;
  bit            model_ready;
  int            clr_edges;
  logic [DW-1:0] exp_q[$];
  int            n_checks;
  int            n_pass;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [DW-1:0] apply_mask(input logic [DW-1:0] old_w,
                                               input logic [DW-1:0] din_w,
                                               input logic [NM-1:0] mask);
    logic [DW-1:0] r;
    r = old_w;
    for (int j = 0; j < NM; j++) if (mask[j]) r[8*j +: 8] = din_w[8*j +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int k = 0; k < DW / 32; k++) w[32*k +: 32] = $urandom();
    return w;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.csb0 = 1'b1; bus.web0 = 1'b1; bus.csb1 = 1'b1;
  endtask

  task automatic p0_write(input int a, input logic [DW-1:0] d, input logic [NM-1:0] m);
    bus.csb0 = 1'b0; bus.web0 = 1'b0; bus.addr0 = AW'(a); bus.din0 = d; bus.wmask0 = m;
  endtask

  task automatic p0_read(input int a);
    bus.csb0 = 1'b0; bus.web0 = 1'b1; bus.addr0 = AW'(a);
  endtask

  task automatic p1_read(input int a);
    bus.csb1 = 1'b0; bus.addr1 = AW'(a);
  endtask

  // Apply the current inputs for one edge, update the model, check outputs.
  task automatic step();
    logic wr, rd0, rd1;
    logic [DW-1:0] nw;
    wr  = model_ready && !bus.csb0 && !bus.web0;
    rd0 = model_ready && !bus.csb0 &&  bus.web0;
    rd1 = model_ready && !bus.csb1;
    nw  = apply_mask(ref_mem[bus.addr0], bus.din0, bus.wmask0);
    if (rd1) exp_dout1 = (wr && bus.addr1 == bus.addr0) ? nw : ref_mem[bus.addr1];
    if (rd0) exp_dout0 = ref_mem[bus.addr0];
    if (wr)  ref_mem[bus.addr0] = nw;
    @(posedge clk0);
    if (!model_ready) begin
      clr_edges++;
      if (clr_edges == DEPTH) begin
        model_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      end
    end
    #1;
    check_eq("dout0", bus.dout0, exp_dout0);
    check_eq("dout1", bus.dout1, exp_dout1);
    check_eq("ready", DW'(bus.ready), DW'(model_ready));
    check_eq("state", DW'(bus.dbg_state), DW'(model_ready ? READY : CLEAR));
  endtask

  task automatic do_reset();
    rst0_n = 1'b0;
    #1;
    check_eq("rst_dout0", bus.dout0, '0);
    check_eq("rst_dout1", bus.dout1, '0);
    check_eq("rst_ready", DW'(bus.ready), '0);
    exp_dout0   = '0;
    exp_dout1   = '0;
    model_ready = 1'b0;
    clr_edges   = 0;
    repeat (2) @(posedge clk0);
    #4 rst0_n = 1'b1;
  endtask

  task automatic wait_ready(input bit attempt_access);
    int cyc;
    cyc = 0;
    while (bus.ready !== 1'b1 && cyc < 200) begin
      if (attempt_access) begin
        p0_write(7, rand_word(), '1);
        p1_read(7);
      end else begin
        idle();
      end
      step();
      cyc++;
    end
    idle();
    check_eq("clear_cycles", DW'(cyc), DW'(DEPTH));
  endtask

  task automatic sweep_zero();
    for (int a = 0; a < DEPTH; a++) begin
      p0_read(a);
      p1_read(DEPTH - 1 - a);
      exp_q.push_back('0);
      exp_q.push_back('0);
      step();
      check_eq("sweep_p0", bus.dout0, exp_q.pop_front());
      check_eq("sweep_p1", bus.dout1, exp_q.pop_front());
    end
    idle();
  endtask

  // ---------------- stimulus ----------------
  logic [DW-1:0] held;

  initial begin
    n_checks = 0; n_pass = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.din0 = '0; bus.wmask0 = '0;
    idle();
    rst0_n = 1'b0;

    // Clear walk with accesses attempted during it; then everything reads zero.
    do_reset();
    wait_ready(1'b1);
    sweep_zero();
    p0_read(7); step(); idle();
    check_eq("ignored_write_a7", bus.dout0, '0);

    // Two partial-mask writes to the same word.
    p0_write(5, {16{8'hA5}}, 16'h00FF); step();
    p0_write(5, {16{8'h3C}}, 16'hFF00); step();
    p0_read(5); step(); idle();
    check_eq("merged_a5", bus.dout0, {{8{8'h3C}}, {8{8'hA5}}});

    // Same-edge write and port-1 read of the same address.
    held = bus.dout0;
    p0_write(9, {32{4'h1}}, 16'hFFFF); p1_read(9); step(); idle();
    check_eq("bypass_dout1", bus.dout1, {32{4'h1}});
    check_eq("bypass_dout0_held", bus.dout0, held);

    // Port-1 holds its data while deselected.
    p0_write(3, rand_word(), 16'hFFFF); step(); idle();
    p1_read(3); step(); idle();
    held = bus.dout1;
    for (int i = 0; i < 4; i++) begin
      p0_write(3, rand_word(), 16'($urandom())); step(); idle();
      check_eq("p1_hold", bus.dout1, held);
    end
    p1_read(3); step(); idle();

    // Zero-mask write leaves memory untouched.
    p0_write(5, rand_word(), 16'h0000); step();
    p0_read(5); step(); idle();
    check_eq("zero_mask_a5", bus.dout0, {{8{8'h3C}}, {8{8'hA5}}});

    // Random traffic on a narrow address window to force collisions.
    for (int i = 0; i < 400; i++) begin
      bus.csb0   = ($urandom_range(0, 3) == 0);
      bus.web0   = 1'($urandom_range(0, 1));
      bus.addr0  = AW'($urandom_range(0, 7));
      bus.din0   = rand_word();
      bus.wmask0 = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom());
      bus.csb1   = ($urandom_range(0, 3) == 0);
      bus.addr1  = ($urandom_range(0, 1) == 1) ? bus.addr0 : AW'($urandom_range(0, 7));
      step();
    end
    idle();

    // Preload, reset from READY, then reset again mid-clear.
    for (int a = 20; a < 28; a++) begin
      p0_write(a, rand_word() | 128'h1, '1); step();
    end
    p0_read(20); p1_read(21); step(); idle();
    do_reset();
    for (int i = 0; i < 30; i++) begin
      idle(); step();
    end
    do_reset();
    wait_ready(1'b0);
    sweep_zero();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_1rw1r_model.md
SRAM_1RW1R_MODEL -- requirements
Module: sram_1rw1r_model

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, address width; RAM_DEPTH = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter WMASK_GRAN, default 8, bits per write-mask lane; NUM_WMASKS = DATA_WIDTH/WMASK_GRAN.
REQ-004 SHALL have parameter INIT_VALUE, default all-zero, DATA_WIDTH-bit word written to every entry after reset.
REQ-005 SHALL have ports: clk0 in 1, the single clock.
REQ-006 SHALL have port rst0_n in 1, asynchronous active-low reset.
REQ-007 SHALL have ports: csb0 in 1 active-low port-0 select; web0 in 1 active-low write enable; wmask0 in NUM_WMASKS lane enables; addr0 in ADDR_WIDTH; din0 in DATA_WIDTH.
REQ-008 SHALL have port dout0 out DATA_WIDTH, port-0 read data.
REQ-009 SHALL have ports: csb1 in 1 active-low port-1 select; addr1 in ADDR_WIDTH; dout1 out DATA_WIDTH, read-only port.
REQ-010 SHALL have port ready out 1, high once the init clear has completed.

Function
REQ-011 SHALL implement an init FSM: CLEAR, then READY.
REQ-012 CLEAR SHALL write INIT_VALUE to the entry at clr_cnt and increment clr_cnt by 1 each cycle, starting at 0.
REQ-013 CLEAR SHALL go to READY on the edge that writes entry RAM_DEPTH-1; clr_cnt SHALL NOT wrap.
REQ-014 ready SHALL be 0 in CLEAR and 1 in READY; the clear SHALL take exactly RAM_DEPTH cycles after reset release.
REQ-015 Port accesses while ready=0 SHALL be ignored: no write, dout0 and dout1 hold.
REQ-016 Port-0 write (READY, csb0=0, web0=0) at edge N SHALL update lane i of mem[addr0] with din0 lane i only where wmask0[i]=1.
REQ-017 Port-0 writes SHALL leave dout0 unchanged.
REQ-018 Port-0 read (csb0=0, web0=1) at edge N SHALL present mem[addr0] on dout0 after edge N (1-cycle latency), registered and held until the next port-0 read.
REQ-019 Port-1 read (csb1=0) at edge N SHALL present mem[addr1] on dout1 after edge N, registered and held.
REQ-020 On a same-edge port-0 write and port-1 read of the same address, dout1 SHALL return the merged post-write word (write-first bypass).
REQ-021 With csb0=1 or csb1=1, that port SHALL perform no access and its dout SHALL hold.
REQ-022 wmask0 all-zero writes SHALL leave memory unchanged.

Reset
REQ-023 Asserting rst0_n low SHALL immediately force ready=0, dout0=0, dout1=0 and clr_cnt=0, and select CLEAR.
REQ-024 Reset asserted mid-CLEAR or in READY SHALL restart the clear from entry 0 after release.
REQ-025 Memory contents SHALL NOT be reset directly; only the CLEAR walk initialises them.

Structure
REQ-026 Shared package sram_pkg SHALL hold the init-state enum typedef sram_init_state_t (CLEAR, READY).
REQ-027 Lane merging (old word, din, mask -> new word) SHALL be the sub-module sram_wmask_merge, used by both the write path and the port-1 bypass.
REQ-028 An elaboration check SHALL fail if DATA_WIDTH mod WMASK_GRAN != 0.

Verification
REQ-029 Release reset, count cycles until ready=1 -> exactly 64 cycles; a port-1 read of every address -> 0.
REQ-030 Write addr0=5, din0=all 0xA5 bytes, wmask0=0x00FF; then write addr0=5, din0=all 0x3C bytes, wmask0=0xFF00; then read addr 5 -> dout0 upper 64 bits 0x3C bytes, lower 64 bits 0xA5 bytes, 1 cycle after the read edge.
REQ-031 Same edge: port-0 write to addr 9 with 0x1111...1111, mask 0xFFFF, and port-1 read of addr 9 -> dout1=0x1111...1111 next cycle; dout0 unchanged.
REQ-032 Assert rst0_n at clear cycle 30 after writes to preload data -> outputs 0 at once; after release a fresh 64-cycle clear runs; all entries read 0.
REQ-033 Port-0 write attempted while ready=0 -> ignored; the entry reads INIT_VALUE after ready.
REQ-034 Read addr 3 on port 1, then hold csb1=1 for 4 cycles while port 0 writes addr 3 -> dout1 keeps the old value.
